// File: rtl/dilithium_io_pkg.sv
// Shared types and constants for the Dilithium host-side byte ingress.
// Word-count constants give host input lengths in 32-bit words (bytes rounded up).
package dilithium_io_pkg;

  localparam int BYTES_PER_WORD = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PACK  = 2'd1,
    DRAIN = 2'd2
  } ingress_state_t;

  function automatic int words_for_bytes(input int n_bytes);
    return (n_bytes + BYTES_PER_WORD - 1) / BYTES_PER_WORD;
  endfunction

  // Keygen consumes the 32-byte seed; sign the secret key; verify public key plus signature.
  localparam int KEYGEN_IN_WORDS    = words_for_bytes(32);
  localparam int SIGN_IN_WORDS_L2   = words_for_bytes(2528);
  localparam int SIGN_IN_WORDS_L3   = words_for_bytes(4000);
  localparam int SIGN_IN_WORDS_L5   = words_for_bytes(4864);
  localparam int VERIFY_IN_WORDS_L2 = words_for_bytes(1312 + 2420);
  localparam int VERIFY_IN_WORDS_L3 = words_for_bytes(1952 + 3293);
  localparam int VERIFY_IN_WORDS_L5 = words_for_bytes(2592 + 4595);

endpackage

// File: rtl/dilithium_word_fifo.sv
// Synchronous word FIFO with occupancy count; head reads as zero while empty.
module dilithium_word_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level,
  output logic [WIDTH-1:0]         head
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      level_q;
  logic             do_push, do_pop;

  assign full    = (level_q == (AW+1)'(DEPTH));
  assign empty   = (level_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign level   = level_q;
  assign head    = empty ? '0 : mem_q[rd_ptr_q];

  // NOTE: the storage array has no reset; pointers and level define validity, so
  // a flush only needs the counters cleared and head is masked while empty.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
    end
  end

endmodule

// File: rtl/dilithium_byte_ingress.sv
// Host byte stream to 32-bit word stream for the Dilithium core: little-endian
// packing, word FIFO, and per-operation word counting with a done pulse.
module dilithium_byte_ingress
  import dilithium_io_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [CNT_W-1:0]       word_count,
  input  logic                   s_valid,
  output logic                   s_ready,
  input  logic [7:0]             s_data,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic [31:0]            m_data,
  output logic                   busy,
  output logic                   done,
  output logic [$clog2(DEPTH):0] level
);

  ingress_state_t   state_q, state_d;
  logic [CNT_W-1:0] in_left_q, in_left_d;
  logic [CNT_W-1:0] out_left_q, out_left_d;
  logic [1:0]       byte_cnt_q, byte_cnt_d;
  logic [23:0]      shift_q, shift_d;
  logic             done_q, done_d;

  logic full, empty, byte_xfer, push, pop;

  // The last byte of a word bypasses the shift register straight into the FIFO,
  // so it may only be taken when the FIFO has room.
  assign s_ready   = (state_q == PACK) && (in_left_q != '0) &&
                     ((byte_cnt_q != 2'd3) || !full);
  assign byte_xfer = s_valid && s_ready;
  assign push      = byte_xfer && (byte_cnt_q == 2'd3);
  assign m_valid   = !empty;
  assign pop       = m_valid && m_ready;
  assign busy      = (state_q != IDLE);
  assign done      = done_q;

  dilithium_word_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (32)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata ({s_data, shift_q}),
    .pop   (pop),
    .full  (full),
    .empty (empty),
    .level (level),
    .head  (m_data)
  );

  // NOTE: every next-state signal takes its hold value first so no path
  // through the block leaves it unassigned and infers a latch.
  always_comb begin
    state_d    = state_q;
    in_left_d  = in_left_q;
    out_left_d = out_left_q;
    byte_cnt_d = byte_cnt_q;
    shift_d    = shift_q;
    done_d     = 1'b0;

    if (byte_xfer) begin
      if (byte_cnt_q != 2'd3) shift_d[{byte_cnt_q, 3'b000} +: 8] = s_data;
      byte_cnt_d = byte_cnt_q + 2'd1;
    end
    if (push && (in_left_q != '0))  in_left_d  = in_left_q - 1'b1;
    if (pop && (out_left_q != '0))  out_left_d = out_left_q - 1'b1;

    case (state_q)
      IDLE: begin
        if (start) begin
          if (word_count != '0) begin
            state_d    = PACK;
            in_left_d  = word_count;
            out_left_d = word_count;
            byte_cnt_d = 2'd0;
            shift_d    = '0;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      PACK: begin
        if (push && (in_left_q == CNT_W'(1))) state_d = DRAIN;
      end
      DRAIN: ;
      default: state_d = IDLE;
    endcase

    if ((state_q != IDLE) && pop && (out_left_q == CNT_W'(1))) begin
      state_d = IDLE;
      done_d  = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      in_left_q  <= '0;
      out_left_q <= '0;
      byte_cnt_q <= '0;
      shift_q    <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      in_left_q  <= in_left_d;
      out_left_q <= out_left_d;
      byte_cnt_q <= byte_cnt_d;
      shift_q    <= shift_d;
      done_q     <= done_d;
    end
  end

endmodule

// File: tb/tb_dilithium_byte_ingress.sv
// Self-checking bench for dilithium_byte_ingress: fixed one-word vectors,
// hand-written corner sequences and a randomized run against a queue model.
module tb_dilithium_byte_ingress;

  localparam int DEPTH = 8;
  localparam int CNT_W = 16;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [CNT_W-1:0] word_count;
  logic             s_valid;
  logic             s_ready;
  logic [7:0]       s_data;
  logic             m_valid;
  logic             m_ready = 1'b0;
  logic [31:0]      m_data;
  logic             busy;
  logic             done;
  logic [LW-1:0]    level;

  dilithium_byte_ingress #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .word_count (word_count),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_data     (s_data),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data),
    .busy       (busy),
    .done       (done),
    .level      (level)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // ---------------- sink driver and monitor ----------------
  int mr_mode = 0;  // 0: hold low, 1: hold high, 2: random
  always @(posedge clk) begin
    #1;
    case (mr_mode)
      0:       m_ready = 1'b0;
      1:       m_ready = 1'b1;
      default: m_ready = 1'($urandom_range(1));
    endcase
  end

  logic [7:0]  acc_q [$];
  logic [31:0] out_q [$];
  int          done_cnt, cyc, last_pop_cyc, done_cyc, stab_err;
  bit          busy_seen, sready_seen, mvalid_seen, prev_hold;
  logic [31:0] prev_data;

  always @(negedge clk) begin
    cyc++;
    if (!rst) begin
      prev_hold = 1'b0;
    end else begin
      if (s_valid && s_ready) acc_q.push_back(s_data);
      if (m_valid && m_ready) begin
        out_q.push_back(m_data);
        last_pop_cyc = cyc;
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (busy)    busy_seen   = 1'b1;
      if (s_ready) sready_seen = 1'b1;
      if (m_valid) mvalid_seen = 1'b1;
      if (prev_hold && (m_data !== prev_data)) stab_err++;
      prev_hold = m_valid && !m_ready;
      prev_data = m_data;
    end
  end

  task automatic clear_mon();
    acc_q.delete();
    out_q.delete();
    done_cnt    = 0;
    stab_err    = 0;
    busy_seen   = 1'b0;
    sready_seen = 1'b0;
    mvalid_seen = 1'b0;
  endtask

  // ---------------- source helpers ----------------
  logic [7:0] src [128];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input int wc);
    start      = 1'b1;
    word_count = CNT_W'(wc);
    tick();
    start      = 1'b0;
  endtask

  // Offers src[first..last] in order, s_valid asserted with probability pct;
  // gives up silently after budget cycles (callers check what was accepted).
  task automatic feed(input int first, input int last, input int pct, input int budget);
    int  i = first;
    int  c = 0;
    bit  acc;
    while (i <= last && c < budget) begin
      s_data  = src[i];
      s_valid = ($urandom_range(99) < pct);
      @(negedge clk);
      acc = s_valid && s_ready;
      tick();
      c++;
      if (acc) i++;
    end
    s_valid = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int c = 0;
    while (done_cnt == 0 && c < budget) begin
      tick();
      c++;
    end
    check({name, "_done_seen"}, done_cnt != 0, 1);
  endtask

  // Reference packing: word j is bytes 4j..4j+3 of the accepted stream, first byte lowest.
  task automatic check_model(input string name);
    logic [31:0] exp;
    check({name, "_nwords"}, out_q.size(), acc_q.size() / 4);
    for (int j = 0; j < out_q.size() && 4 * j + 3 < acc_q.size(); j++) begin
      exp = 32'(acc_q[4*j]) + (32'(acc_q[4*j+1]) << 8) +
            (32'(acc_q[4*j+2]) << 16) + (32'(acc_q[4*j+3]) << 24);
      check($sformatf("%s_word%0d", name, j), out_q[j], exp);
    end
    check({name, "_mdata_stable"}, stab_err, 0);
  endtask

  function automatic logic [31:0] head_or_x(input int idx);
    return (out_q.size() > idx) ? out_q[idx] : 32'hxxxx_xxxx;
  endfunction

  // ---------------- single-word vectors ----------------
  typedef struct {
    logic [31:0] stream;  // first byte sent in bits [31:24]
    int          mr;
    int          pct;
    logic [31:0] exp_word;
  } vec_t;

  vec_t vecs [6];

  initial begin
    int n;
    logic [31:0] w;

    vecs[0] = '{32'h1122_3344, 1, 100, 32'h4433_2211};
    vecs[1] = '{32'h0000_0000, 1, 100, 32'h0000_0000};
    vecs[2] = '{32'hFF00_0000, 2,  50, 32'h0000_00FF};
    vecs[3] = '{32'h0000_00FF, 2,  70, 32'hFF00_0000};
    vecs[4] = '{32'hDEAD_BEEF, 1,  40, 32'hEFBE_ADDE};
    vecs[5] = '{32'h0102_0304, 2, 100, 32'h0403_0201};

    rst = 1'b0; start = 1'b0; word_count = '0; s_valid = 1'b0; s_data = '0;
    clear_mon();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_s_ready", s_ready, 0);
    check("rst_m_valid", m_valid, 0);
    check("rst_m_data",  m_data,  0);
    check("rst_busy",    busy,    0);
    check("rst_done",    done,    0);
    check("rst_level",   level,   0);
    rst = 1'b1;
    tick();

    // ---- table-driven one-word operations ----
    foreach (vecs[v]) begin
      mr_mode = vecs[v].mr;
      w = vecs[v].stream;
      for (int b = 0; b < 4; b++) src[b] = w[31 - 8*b -: 8];
      tick();
      clear_mon();
      pulse_start(1);
      feed(0, 3, vecs[v].pct, 100);
      wait_done($sformatf("vec%0d", v), 100);
      check($sformatf("vec%0d_word", v), head_or_x(0), vecs[v].exp_word);
      check($sformatf("vec%0d_ndone", v), done_cnt, 1);
    end

    // ---- basic packing: two words back-to-back ----
    mr_mode = 1;
    for (int b = 0; b < 8; b++) src[b] = 8'((b + 1) * 8'h11);
    tick();
    clear_mon();
    pulse_start(2);
    @(negedge clk);
    check("basic_busy_after_start", busy, 1);
    tick();
    feed(0, 7, 100, 40);
    wait_done("basic", 40);
    tick();
    @(negedge clk);
    check("basic_word0", head_or_x(0), 32'h4433_2211);
    check("basic_word1", head_or_x(1), 32'h8877_6655);
    check("basic_ndone", done_cnt, 1);
    check("basic_done_timing", done_cyc, last_pop_cyc + 1);
    check("basic_busy_after", busy, 0);
    tick();

    // ---- zero length ----
    clear_mon();
    s_valid = 1'b1;
    s_data  = 8'h5A;
    start = 1'b1; word_count = '0;
    @(negedge clk);
    check("zero_done_early", done, 0);
    tick();
    start = 1'b0;
    @(negedge clk);
    check("zero_done_next", done, 1);
    tick();
    @(negedge clk);
    check("zero_done_once", done, 0);
    repeat (4) tick();
    s_valid = 1'b0;
    check("zero_ndone", done_cnt, 1);
    check("zero_no_sready", sready_seen, 0);
    check("zero_no_mvalid", mvalid_seen, 0);
    check("zero_no_busy", busy_seen, 0);

    // ---- backpressure: FIFO fills, last byte of word 9 blocked ----
    mr_mode = 0;
    for (int b = 0; b < 40; b++) src[b] = 8'($urandom);
    tick();
    clear_mon();
    pulse_start(10);
    feed(0, 39, 100, 60);
    @(negedge clk);
    check("bp_bytes_accepted", acc_q.size(), 35);
    check("bp_s_ready_low", s_ready, 0);
    check("bp_level_full", level, DEPTH);
    check("bp_no_pops", out_q.size(), 0);
    tick();
    mr_mode = 1;
    feed(35, 39, 100, 60);
    wait_done("bp", 60);
    check_model("bp");
    check("bp_ndone", done_cnt, 1);
    check("bp_bytes_total", acc_q.size(), 40);

    // ---- host stalls with random sink backpressure, excess bytes offered ----
    mr_mode = 2;
    for (int b = 0; b < 72; b++) src[b] = 8'($urandom);
    tick();
    clear_mon();
    pulse_start(16);
    feed(0, 71, 60, 400);
    wait_done("stall", 400);
    repeat (4) tick();
    check("stall_bytes_total", acc_q.size(), 64);
    n = 0;
    for (int b = 0; b < acc_q.size() && b < 64; b++) if (acc_q[b] !== src[b]) n++;
    check("stall_bytes_in_order", n, 0);
    check_model("stall");
    check("stall_ndone", done_cnt, 1);

    // ---- start while busy is ignored ----
    mr_mode = 2;
    for (int b = 0; b < 24; b++) src[b] = 8'($urandom);
    tick();
    clear_mon();
    pulse_start(3);
    feed(0, 4, 100, 20);
    pulse_start(5);
    feed(5, 23, 70, 150);
    wait_done("ign", 150);
    repeat (10) tick();
    check("ign_bytes_total", acc_q.size(), 12);
    check_model("ign");
    check("ign_ndone", done_cnt, 1);
    check("ign_busy_after", busy, 0);

    // ---- asynchronous reset mid-operation ----
    mr_mode = 0;
    for (int b = 0; b < 8; b++) src[b] = 8'($urandom);
    tick();
    clear_mon();
    pulse_start(4);
    feed(0, 5, 100, 20);
    @(negedge clk);
    check("mid_m_valid_before", m_valid, 1);
    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    check("mid_s_ready", s_ready, 0);
    check("mid_m_valid", m_valid, 0);
    check("mid_m_data",  m_data,  0);
    check("mid_busy",    busy,    0);
    check("mid_done",    done,    0);
    check("mid_level",   level,   0);
    @(negedge clk);
    rst = 1'b1;
    mr_mode = 1;
    src[0] = 8'hAA; src[1] = 8'hBB; src[2] = 8'hCC; src[3] = 8'hDD;
    tick();
    clear_mon();
    pulse_start(1);
    feed(0, 3, 100, 20);
    wait_done("post_rst", 20);
    check("post_rst_word", head_or_x(0), 32'hDDCC_BBAA);
    check("post_rst_nwords", out_q.size(), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dilithium_byte_ingress.md
Name: dilithium_byte_ingress

Overview:
- Upstream feeder for the Dilithium core's 32-bit input stream (data_i/valid_i/ready_i).
- Accepts a host byte stream and packs it little-endian into 32-bit words.
- Buffers packed words in a DEPTH-word FIFO and presents them with a valid/ready handshake.
- Counts words against a per-operation length loaded at start, stops accepting input at the end of the operation and pulses done when the last word has been consumed.

Parameters:
- DEPTH, 8, FIFO depth in 32-bit words; power of two, at least 2.
- CNT_W, 16, width of the word-count and remaining-word counters.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  reset, asynchronous assert, active-low (0 = reset).
- start  in  1  one-cycle pulse; begins an operation, samples word_count.
- word_count  in  CNT_W  number of 32-bit words in the operation.
- s_valid  in  1  host byte valid.
- s_ready  out  1  ingress accepts a byte this cycle.
- s_data  in  8  host byte.
- m_valid  out  1  packed word available (drives core valid_i).
- m_ready  in  1  core accepts the word (core ready_i).
- m_data  out  32  packed word (drives core data_i).
- busy  out  1  operation in progress.
- done  out  1  one-cycle pulse when the operation completes.
- level  out  $clog2(DEPTH)+1  FIFO occupancy.

Behaviour:
- Reset values (rst=0, asynchronous): s_ready=0, m_valid=0, m_data=0, busy=0, done=0, level=0. FIFO is flushed, byte_cnt=0, partial word discarded, counters cleared, state=IDLE.
- State machine: IDLE, PACK, DRAIN.
- IDLE:
  - start with word_count>0 -> PACK; in_left=out_left=word_count, byte_cnt=0, busy=1 next cycle.
  - start with word_count=0 -> stay IDLE; done=1 the following cycle.
- PACK:
  - s_ready = (in_left!=0) && (byte_cnt!=3 || !full).
  - A byte transfers when s_valid && s_ready.
  - Byte k (k=0..3) goes to bits [8k+7:8k] of the shift register.
  - On the byte with byte_cnt==3, the assembled word is pushed into the FIFO, byte_cnt wraps to 0 and in_left decrements.
  - When in_left reaches 0: s_ready drops the next cycle and state -> DRAIN.
- DRAIN: s_ready=0; wait for out_left==0.
- FIFO push and pop:
  - The push condition never depends on m_ready. When full, a push waits even if a pop occurs in the same cycle.
  - A simultaneous push and pop with the FIFO not full keeps level unchanged.
- Output side:
  - m_valid = !empty, in any state.
  - m_data = FIFO head.
  - Each m_valid && m_ready handshake pops one word and decrements out_left.
- Latency: a word completed at edge t gives m_valid=1 in the cycle after t when the FIFO was empty. m_data stays stable while m_valid && !m_ready.
- Completion: when the pop decrementing out_left to 0 occurs at edge t, done=1 for the cycle after t, busy=0 and state=IDLE.
- start while busy=1: ignored, counters untouched.
- Excess bytes: never accepted, because s_ready=0 once in_left=0.
- Mid-operation reset: rst=0 aborts immediately to reset values. Nothing is replayed.
- Counter arithmetic: in_left and out_left are unsigned CNT_W. They decrement only while non-zero and never wrap.

Decomposition:
- Package dilithium_io_pkg holds:
  - ingress_state_t enum {IDLE, PACK, DRAIN};
  - BYTES_PER_WORD=4;
  - the per-mode word-count constants (keygen/sign/verify input lengths per security level), for use by whatever drives word_count.
- Sub-module dilithium_word_fifo: synchronous FIFO, parameters DEPTH and WIDTH=32.
  - Ports: push, pop, full, empty, level, head.
  - Uses the same async active-low rst.
- The top holds the FSM, the byte packer and the counters.

Test Plan:
- Basic packing: start, word_count=2, m_ready=1, bytes 11,22,...,88 back-to-back -> m_data 0x44332211 then 0x88776655. done pulses exactly once, the cycle after the second pop; busy=0 afterwards.
- Zero length: start with word_count=0 -> no s_ready, m_valid stays 0, done=1 the next cycle, busy never 1.
- Backpressure: DEPTH=8, word_count=10, m_ready=0, continuous bytes -> 35 bytes accepted. s_ready=0 on byte 36 with level=8. Releasing m_ready drains 10 words in order, then done.
- Host stalls: random s_valid gaps plus m_ready toggling, word_count=16 -> words equal the reference packing of the byte stream. No byte accepted after the 64th.
- start ignored: start pulsed while busy with word_count=5 -> original count of 3 governs. Exactly 3 words out, one done.
- Reset mid-operation: rst=0 after 6 bytes of a 4-word operation -> all outputs 0 asynchronously, level=0. A new start with word_count=1 and bytes AA,BB,CC,DD gives m_data=0xDDCCBBAA.
